// File: rtl/color_scan_sequencer_pkg.sv
// Shared encodings for the colour sensor scan controller.
// Filter select codes match the sensor S2/S3 pin mapping.
// The helper function sizes counters from parameters.
`timescale 1ns/1ps
package color_pkg;

  // Sensor S2/S3 photodiode filter select
  typedef enum logic [1:0] {
    FILT_RED   = 2'd0,
    FILT_BLUE  = 2'd1,
    FILT_CLEAR = 2'd2,
    FILT_GREEN = 2'd3
  } filt_e;

  // Reported dominant colour
  typedef enum logic [1:0] {
    COL_NONE  = 2'd0,
    COL_RED   = 2'd1,
    COL_GREEN = 2'd2,
    COL_BLUE  = 2'd3
  } color_e;

  // Scan controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2,
    ST_DECIDE = 2'd3
  } state_e;

  // Channel currently being measured
  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } ch_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/color_scan_sequencer_cs_edge_sync.sv
// Purpose: bring an asynchronous pulse train into the clock domain and flag rising edges.
// Latency: 2-3 clocks from input rise to o_rise (two sync flops plus one history flop).
// Backpressure: none; at most one edge per clock is reported, faster inputs under-count.
`timescale 1ns/1ps
module cs_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Two-flop synchronizer followed by a one-flop history for edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/color_scan_sequencer.sv
// Purpose: sequence R->G->B filters, count sensor edges per gate window, report counts and dominant colour.
// Latency: done pulses 3*(SETTLE_CYCLES+GATE_CYCLES)+1 clocks after start is accepted.
// Backpressure: start is only honoured in IDLE; requests while busy are dropped, not queued.
`timescale 1ns/1ps
module color_scan_sequencer
  import color_pkg::*;
#(
  parameter int GATE_CYCLES   = 500,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 10,
  parameter int MIN_COUNT     = 4
) (
  input  logic             clk_1MHz,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             cs_out,
  output logic [1:0]       filter,
  output logic             busy,
  output logic             done,
  output logic [1:0]       color,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt
);

  localparam int CYC_MAX = max_int(GATE_CYCLES, SETTLE_CYCLES);
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam logic [CYC_W-1:0] GATE_LAST   = CYC_W'(GATE_CYCLES - 1);
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W:0]   MIN_C       = (CNT_W + 1)'(MIN_COUNT);

  state_e           r_state;
  ch_e              r_ch;
  filt_e            r_filter;
  color_e           r_color;
  logic [CYC_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_work;
  logic [CNT_W-1:0] r_sh_red;
  logic [CNT_W-1:0] r_sh_green;
  logic [CNT_W-1:0] r_sh_blue;
  logic [CNT_W-1:0] r_red_cnt;
  logic [CNT_W-1:0] r_green_cnt;
  logic [CNT_W-1:0] r_blue_cnt;
  logic             r_busy;
  logic             r_done;

  logic             w_rise;
  logic [CNT_W-1:0] w_work_nxt;
  color_e           w_color;

  cs_edge_sync u_edge_sync (
    .i_clk   (clk_1MHz),
    .i_rst_n (rst_n),
    .i_async (cs_out),
    .o_rise  (w_rise)
  );

  // Working count including this cycle's edge, held at all-ones once full
  always_comb begin
    w_work_nxt = r_work;
    if (w_rise && !(&r_work)) begin
      w_work_nxt = r_work + CNT_W'(1);
    end
  end

  // Dominant colour from the shadow counts; ties favour red, then blue, then green
  always_comb begin
    w_color = COL_NONE;
    if (({1'b0, r_sh_red} < MIN_C) && ({1'b0, r_sh_green} < MIN_C) &&
        ({1'b0, r_sh_blue} < MIN_C)) begin
      w_color = COL_NONE;
    end else if ((r_sh_red >= r_sh_blue) && (r_sh_red >= r_sh_green)) begin
      w_color = COL_RED;
    end else if (r_sh_blue >= r_sh_green) begin
      w_color = COL_BLUE;
    end else begin
      w_color = COL_GREEN;
    end
  end

  // Scan FSM with registered filter/busy/done/results
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ch        <= CH_R;
      r_filter    <= FILT_CLEAR;
      r_color     <= COL_NONE;
      r_cyc       <= '0;
      r_work      <= '0;
      r_sh_red    <= '0;
      r_sh_green  <= '0;
      r_sh_blue   <= '0;
      r_red_cnt   <= '0;
      r_green_cnt <= '0;
      r_blue_cnt  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state  <= ST_SETTLE;
            r_ch     <= CH_R;
            r_filter <= FILT_RED;
            r_cyc    <= '0;
            r_work   <= '0;
            r_busy   <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_cyc == SETTLE_LAST) begin
            r_state <= ST_GATE;
            r_cyc   <= '0;
          end else begin
            r_cyc <= r_cyc + CYC_W'(1);
          end
        end
        ST_GATE: begin
          if (r_cyc == GATE_LAST) begin
            r_cyc  <= '0;
            r_work <= '0;
            case (r_ch)
              CH_R: begin
                r_sh_red <= w_work_nxt;
                r_ch     <= CH_G;
                r_filter <= FILT_GREEN;
                r_state  <= ST_SETTLE;
              end
              CH_G: begin
                r_sh_green <= w_work_nxt;
                r_ch       <= CH_B;
                r_filter   <= FILT_BLUE;
                r_state    <= ST_SETTLE;
              end
              default: begin
                r_sh_blue <= w_work_nxt;
                r_state   <= ST_DECIDE;
              end
            endcase
          end else begin
            r_cyc  <= r_cyc + CYC_W'(1);
            r_work <= w_work_nxt;
          end
        end
        ST_DECIDE: begin
          r_red_cnt   <= r_sh_red;
          r_green_cnt <= r_sh_green;
          r_blue_cnt  <= r_sh_blue;
          r_color     <= w_color;
          r_done      <= 1'b1;
          r_cyc       <= '0;
          r_work      <= '0;
          r_ch        <= CH_R;
          if (continuous) begin
            r_state  <= ST_SETTLE;
            r_filter <= FILT_RED;
          end else begin
            r_state  <= ST_IDLE;
            r_filter <= FILT_CLEAR;
            r_busy   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign filter    = r_filter;
  assign busy      = r_busy;
  assign done      = r_done;
  assign color     = r_color;
  assign red_cnt   = r_red_cnt;
  assign green_cnt = r_green_cnt;
  assign blue_cnt  = r_blue_cnt;

endmodule

// File: tb/tb_color_scan_sequencer.sv
// Bench for color_scan_sequencer: default-parameter instance for timing/table cases,
// small saturating instance (CNT_W=4) for random scans against a reference model.
// Inputs change 1 time unit after the rising clock edge; outputs are sampled there too.
`timescale 1ns/1ps
module tb_color_scan_sequencer;

  localparam int G0 = 500;
  localparam int S0 = 2;
  localparam int W0 = 10;
  localparam int M0 = 4;
  localparam int T0 = 3 * (S0 + G0) + 1;

  localparam int G1 = 70;
  localparam int S1 = 3;
  localparam int W1 = 4;
  localparam int M1 = 4;
  localparam int T1 = 3 * (S1 + G1) + 1;
  localparam int SAT1 = (1 << W1) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n = 1'b1, rst1_n = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic cont0 = 1'b0, cont1 = 1'b0;
  logic cs0 = 1'b0, cs1 = 1'b0;
  logic [1:0] filt0, filt1, col0, col1;
  logic busy0, busy1, done0, done1;
  logic [W0-1:0] r0, g0, b0;
  logic [W1-1:0] r1, g1, b1;

  color_scan_sequencer #(.GATE_CYCLES(G0), .SETTLE_CYCLES(S0), .CNT_W(W0), .MIN_COUNT(M0)) u_dut0 (
    .clk_1MHz(clk), .rst_n(rst0_n), .start(start0), .continuous(cont0), .cs_out(cs0),
    .filter(filt0), .busy(busy0), .done(done0), .color(col0),
    .red_cnt(r0), .green_cnt(g0), .blue_cnt(b0));

  color_scan_sequencer #(.GATE_CYCLES(G1), .SETTLE_CYCLES(S1), .CNT_W(W1), .MIN_COUNT(M1)) u_dut1 (
    .clk_1MHz(clk), .rst_n(rst1_n), .start(start1), .continuous(cont1), .cs_out(cs1),
    .filter(filt1), .busy(busy1), .done(done1), .color(col1),
    .red_cnt(r1), .green_cnt(g1), .blue_cnt(b1));

  // Edge index bookkeeping and the history of cs1 as sampled at every rising edge
  int cyc_cnt = 0;
  bit hist1 [0:65535];
  always @(posedge clk) begin
    hist1[cyc_cnt % 65536] = cs1;
    cyc_cnt = cyc_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_tol(input string nm, input int act, input int exp, input int tol);
    n_checks++;
    if (act < exp - tol || act > exp + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +-%0d", nm, act, exp, tol);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Square wave of period p clocks, high in the first half; p<=0 means held low
  function automatic logic wave(input int p, input int lt);
    if (p <= 0) return 1'b0;
    return ((lt % p) < (p / 2));
  endfunction

  // Colour rule: none below threshold, ties resolve red > blue > green
  function automatic int ref_color(input int r, input int g, input int b, input int mn);
    int mx;
    mx = (r > g) ? r : g;
    mx = (mx > b) ? mx : b;
    if (mx < mn) return 0;
    if (r >= b && r >= g) return 1;
    if (b >= g) return 3;
    return 2;
  endfunction

  // One scan on the default instance with a square wave per channel phase
  task automatic run_scan0(input string nm, input int pr, input int pg, input int pb,
                           input int er, input int eg, input int eb, input int ecol);
    int c, lt, seen;
    seen = 0;
    start0 = 1'b1;
    for (int t = 0; t < T0 + 20 && seen == 0; t++) begin
      c  = t / (S0 + G0);
      if (c > 2) c = 2;
      lt = t - c * (S0 + G0);
      cs0 = (c == 0) ? wave(pr, lt) : (c == 1) ? wave(pg, lt) : wave(pb, lt);
      step();
      start0 = 1'b0;
      if (t == 0) begin
        check({nm, "_filter_red"}, int'(filt0), 0);
        check({nm, "_busy_on"}, int'(busy0), 1);
      end
      if (t == S0 + G0) check({nm, "_filter_green"}, int'(filt0), 3);
      if (t == 2 * (S0 + G0)) check({nm, "_filter_blue"}, int'(filt0), 1);
      if (t == T0 - 1) check({nm, "_busy_before_done"}, int'(busy0), 1);
      if (done0) begin
        seen = 1;
        check({nm, "_done_latency"}, t, T0);
      end
    end
    cs0 = 1'b0;
    check({nm, "_done_seen"}, seen, 1);
    check_tol({nm, "_red_cnt"}, int'(r0), er, 1);
    check_tol({nm, "_green_cnt"}, int'(g0), eg, 1);
    check_tol({nm, "_blue_cnt"}, int'(b0), eb, 1);
    check({nm, "_color"}, int'(col0), ecol);
    check({nm, "_filter_clear"}, int'(filt0), 2);
    check({nm, "_busy_off"}, int'(busy0), 0);
    step();
    check({nm, "_done_one_cycle"}, int'(done0), 0);
  endtask

  // One scan on the small instance; mode 0 random density per channel, mode 1 clk/4 square
  task automatic run_scan1(input string nm, input int mode);
    int th[3];
    int cnt[3];
    int k, c, lt, seen, e0, e1;
    for (int i = 0; i < 3; i++) th[i] = int'($urandom_range(0, 60));
    k = cyc_cnt;
    seen = 0;
    start1 = 1'b1;
    for (int t = 0; t < T1 + 20 && seen == 0; t++) begin
      c  = t / (S1 + G1);
      if (c > 2) c = 2;
      lt = t - c * (S1 + G1);
      cs1 = (mode == 1) ? wave(4, lt) : (int'($urandom_range(0, 99)) < th[c]);
      step();
      start1 = 1'b0;
      if (done1) begin
        seen = 1;
        check({nm, "_done_latency"}, t, T1);
      end
    end
    check({nm, "_done_seen"}, seen, 1);
    // Reference: rising transitions of the sampled input, seen two edges late,
    // counted over each channel's gate window and clipped at the counter maximum
    for (int ch = 0; ch < 3; ch++) begin
      cnt[ch] = 0;
      e0 = k + ch * (S1 + G1) + S1 + 1;
      e1 = k + (ch + 1) * (S1 + G1);
      for (int e = e0; e <= e1; e++) begin
        if (hist1[(e - 2) % 65536] && !hist1[(e - 3) % 65536]) cnt[ch]++;
      end
      if (cnt[ch] > SAT1) cnt[ch] = SAT1;
    end
    check({nm, "_red_cnt"}, int'(r1), cnt[0]);
    check({nm, "_green_cnt"}, int'(g1), cnt[1]);
    check({nm, "_blue_cnt"}, int'(b1), cnt[2]);
    check({nm, "_color"}, int'(col1), ref_color(cnt[0], cnt[1], cnt[2], M1));
    check({nm, "_filter_clear"}, int'(filt1), 2);
  endtask

  typedef struct {
    int pr; int pg; int pb;
    int er; int eg; int eb;
    int ecol;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int seen, busy_low, ndone;
    int d[3];

    // Table: square-wave periods in clocks per channel and expected results
    vecs[0] = '{20, 100, 50, 25, 5, 10, 1};    // 50/10/20 kHz, red dominant
    vecs[1] = '{50, 100, 50, 10, 5, 10, 1};    // red == blue > green, red wins
    vecs[2] = '{0, 0, 0, 0, 0, 0, 0};          // held low, no object
    vecs[3] = '{100, 20, 50, 5, 25, 10, 2};    // green dominant
    vecs[4] = '{100, 50, 20, 5, 10, 25, 3};    // blue dominant
    vecs[5] = '{0, 200, 0, 0, 2, 0, 0};        // max below MIN_COUNT
    vecs[6] = '{0, 125, 0, 0, 4, 0, 2};        // max exactly MIN_COUNT

    #2;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    step(); step(); step();
    rst0_n = 1'b1;
    rst1_n = 1'b1;

    // Idle with a toggling sensor: nothing may move
    for (int i = 0; i < 20; i++) begin
      cs0 = ~cs0;
      cs1 = (i % 3 == 0);
      step();
    end
    cs0 = 1'b0;
    cs1 = 1'b0;
    check("idle0_filter", int'(filt0), 2);
    check("idle0_busy", int'(busy0), 0);
    check("idle0_done", int'(done0), 0);
    check("idle0_color", int'(col0), 0);
    check("idle0_counts", int'(r0) + int'(g0) + int'(b0), 0);
    check("idle1_filter", int'(filt1), 2);
    check("idle1_busy", int'(busy1), 0);
    check("idle1_counts", int'(r1) + int'(g1) + int'(b1), 0);

    for (int i = 0; i < 7; i++) begin
      run_scan0($sformatf("vec%0d", i), vecs[i].pr, vecs[i].pg, vecs[i].pb,
                vecs[i].er, vecs[i].eg, vecs[i].eb, vecs[i].ecol);
    end

    // Reset in the middle of the green gate window
    start0 = 1'b1;
    for (int t = 0; t < (S0 + G0) + S0 + 100; t++) begin
      cs0 = wave(20, t);
      step();
      start0 = 1'b0;
    end
    #2;
    rst0_n = 1'b0;
    #1;
    check("rst_filter", int'(filt0), 2);
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_color", int'(col0), 0);
    check("rst_green_cnt", int'(g0), 0);
    check("rst_counts", int'(r0) + int'(b0), 0);
    step(); step(); step();
    rst0_n = 1'b1;
    seen = 0;
    busy_low = 0;
    for (int t = 0; t < T0 + 100; t++) begin
      cs0 = wave(20, t);
      step();
      if (done0) seen++;
      if (busy0) busy_low++;
    end
    cs0 = 1'b0;
    check("rst_no_done", seen, 0);
    check("rst_no_busy", busy_low, 0);
    run_scan0("restart", 20, 100, 50, 25, 5, 10, 1);

    // Continuous mode with a stray start mid-scan
    cont0 = 1'b1;
    ndone = 0;
    busy_low = 0;
    for (int i = 0; i < 3; i++) d[i] = -1;
    for (int t = 0; t < 3 * T0 + 50 && ndone < 3; t++) begin
      start0 = (t == 0 || t == T0 + 700);
      step();
      start0 = 1'b0;
      if (done0) begin
        d[ndone] = t;
        ndone++;
        if (ndone == 2) cont0 = 1'b0;
      end else if (t > 0 && !busy0) begin
        busy_low++;
      end
    end
    cont0 = 1'b0;
    check("cont_done_count", ndone, 3);
    check("cont_first_done", d[0], T0);
    check("cont_period1", d[1] - d[0], T0);
    check("cont_period2", d[2] - d[1], T0);
    check("cont_busy_never_drops", busy_low, 0);
    check("cont_end_busy", int'(busy0), 0);
    step();
    check("cont_end_filter", int'(filt0), 2);
    check("cont_end_done", int'(done0), 0);

    // Saturation on the narrow-counter instance
    run_scan1("sat", 1);
    check("sat_red", int'(r1), SAT1);
    check("sat_green", int'(g1), SAT1);
    check("sat_blue", int'(b1), SAT1);
    check("sat_color", int'(col1), 1);

    for (int i = 0; i < 40; i++) begin
      step();
      run_scan1($sformatf("rand%0d", i), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/color_scan_sequencer.md
# color_scan_sequencer

Controller that drives the colour sensor's photodiode filter-select lines and measures its frequency output (`cs_out`) through a fixed red → green → blue scan, all in the `clk_1MHz` domain. It sequences the filter, inserts a settling gap after each filter change, counts synchronized `cs_out` rising edges over a programmable gate window, and reports per-channel counts plus the dominant colour. It replaces free-running filter cycling with a start/busy/done handshake, so a top-level FSM or UART reporter can request scans on demand or continuously.

## Interface
- `GATE_CYCLES`, default 500: clocks per channel counting window, minimum 1.
- `SETTLE_CYCLES`, default 2: clocks after a filter change before counting starts, minimum 1.
- `CNT_W`, default 10: width of the per-channel edge counters.
- `MIN_COUNT`, default 4: if the largest channel count is below this value, `color` = 0 (no object).
- `clk_1MHz` input 1: sole clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: level-sampled request; accepted only in IDLE.
- `continuous` input 1: when high at DECIDE, a new scan begins without a new `start`.
- `cs_out` input 1: asynchronous sensor frequency output.
- `filter` output 2: sensor S2/S3 select. 0 = red, 1 = blue, 2 = clear, 3 = green.
- `busy` output 1: high from start acceptance until the cycle `done` pulses.
- `done` output 1: one-cycle pulse; results are valid in that cycle and held afterwards.
- `color` output 2: 0 = none, 1 = red, 2 = green, 3 = blue.
- `red_cnt`, `green_cnt`, `blue_cnt` output CNT_W: latched counts from the last completed scan.

## Operation
- States: IDLE, SETTLE, GATE, DECIDE. A channel index `ch` ∈ {R, G, B} is advanced on each GATE→SETTLE transition.
- IDLE:
  - `filter` = 2 (clear), `busy` = 0.
  - When `start` = 1: go to SETTLE with `ch` = R, `filter` = 0, working counter cleared, `busy` = 1.
- SETTLE:
  - Lasts SETTLE_CYCLES clocks, then goes to GATE.
  - `cs_out` edges are ignored.
- GATE:
  - Lasts GATE_CYCLES clocks.
  - Each detected rising edge increments the working counter. The counter saturates at 2^CNT_W−1 and never wraps.
  - At the end of the window the count is stored into the channel's shadow register and the working counter is cleared.
  - ch R → G: `filter` = 3, go to SETTLE. ch G → B: `filter` = 1, go to SETTLE. ch B → DECIDE.
- DECIDE (one clock):
  - Copy the shadow registers to the `*_cnt` outputs.
  - Compute `color`:
    - max < MIN_COUNT → 0.
    - Else red if red ≥ blue and red ≥ green.
    - Else blue if blue ≥ green.
    - Else green.
    - Ties therefore resolve red > blue > green.
  - Pulse `done`.
  - If `continuous` = 1: go to SETTLE with ch = R and `filter` = 0, `busy` stays 1. Otherwise go to IDLE with `filter` = 2.
- `start` while `busy` = 1 is ignored, not queued.
- An edge detected in the same cycle that a GATE window ends is counted for the ending channel.
- `cs_out` path: a 2-flop synchronizer followed by a rising-edge detector. At most one edge per clock is counted, so input frequencies above clk/2 under-count. That limit is accepted.

## Timing
- Reset values: `filter` = 2, `busy` = 0, `done` = 0, `color` = 0, all `*_cnt` = 0, state IDLE, synchronizer flops 0.
- `start` high at edge k → `filter` = 0 and `busy` = 1 after edge k.
- `done` is high during the cycle following edge k + 3·(SETTLE_CYCLES+GATE_CYCLES) + 1. With defaults that is edge k+1507.
- In continuous mode, consecutive `done` pulses are 3·(SETTLE_CYCLES+GATE_CYCLES)+1 clocks apart.
- Edge-detect latency from a `cs_out` rise to the counter increment: 2–3 clocks. Edges still in the synchronizer when GATE ends are discarded.
- `rst_n` low mid-scan: all outputs return to reset values immediately (asynchronously), with no `done`. Deassertion is synchronized by the system reset generator.

## Structure
- Package `color_pkg`:
  - Filter codes `FILT_RED` = 0, `FILT_BLUE` = 1, `FILT_CLEAR` = 2, `FILT_GREEN` = 3.
  - Colour codes `COL_NONE` / `COL_RED` / `COL_GREEN` / `COL_BLUE`.
  - State and channel enums.
- Sub-module `cs_edge_sync`: 2-flop synchronizer plus rising-edge pulse, async active-low reset. Reusable by other sensor blocks.
- Main body: FSM, a cycle counter sized to max(GATE_CYCLES, SETTLE_CYCLES), the saturating working counter, three shadow registers, and the decide logic.

## Test plan
- Reset, then idle 20 clocks → `filter` = 2, `busy` = 0, `color` = 0, counts 0; `cs_out` toggling has no effect.
- Defaults; `cs_out` at 50 kHz under red, 10 kHz under green, 20 kHz under blue, single `start` → `done` at k+1507, `red_cnt` ≈ 25 ±1, `green_cnt` ≈ 5 ±1, `blue_cnt` ≈ 10 ±1, `color` = 1, `filter` back to 2.
- Equal red and blue counts above green → `color` = 1. `cs_out` held low for a whole scan → all counts 0, `color` = 0.
- CNT_W = 4, `cs_out` at clk/4 → every count = 15 (saturated), no wrap.
- `continuous` held high → `done` pulses every 1507 clocks and `busy` never drops. A `start` pulse mid-scan changes nothing.
- `rst_n` asserted during the green GATE → outputs return to reset values at once, no `done` is produced, and the next `start` restarts from red.
